// File: rtl/traffic_scheduler.sv
// Game-state sequencer for the road lanes: runs the IDLE/LOAD/RUN/PAUSED/CRASH/OVER
// machine and produces per-lane movement strobes whose rate depends on lane and level.
module traffic_scheduler #(
    parameter int                     NUM_LANES   = 4,
    parameter int                     PRESCALE    = 500000,
    parameter logic [4*NUM_LANES-1:0] LANE_BASE   = 16'h8642,
    parameter int                     CRASH_TICKS = 8,
    parameter int                     LIVES       = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   pause,
    input  logic                   collision,
    input  logic                   level_up,
    output logic [NUM_LANES-1:0]   move_tick,
    output logic                   lane_load,
    output logic [2*NUM_LANES-1:0] lane_dir,
    output logic [2:0]             level,
    output logic [1:0]             lives,
    output logic [2:0]             state
);

    localparam int PW = $clog2(PRESCALE);
    localparam int CW = $clog2(CRASH_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        CRASH  = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t          cur_state;
    state_t          next_state;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   crash_cnt;
    logic            base_tick;
    logic            crash_done;
    logic [3:0]      period   [NUM_LANES];
    logic [3:0]      lane_cnt [NUM_LANES];

    assign state      = cur_state;
    assign base_tick  = ((cur_state == RUN) || (cur_state == CRASH)) && (presc == PW'(PRESCALE - 1));
    assign crash_done = (cur_state == CRASH) && base_tick && (crash_cnt == CW'(CRASH_TICKS - 1));

    // Per-lane period shrinks with level but never drops below one base tick.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [3:0] base;
        assign base                = LANE_BASE[4*g +: 4];
        assign period[g]           = (base > {1'b0, level}) ? (base - {1'b0, level}) : 4'd1;
        assign lane_dir[2*g +: 2]  = {1'b0, 1'(g % 2)};
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (start) next_state = LOAD;
            OVER:    if (start) next_state = LOAD;
            LOAD:    next_state = RUN;
            RUN: begin
                if (collision)     next_state = CRASH;
                else if (level_up) next_state = LOAD;
                else if (pause)    next_state = PAUSED;
            end
            PAUSED:  if (pause) next_state = RUN;
            CRASH:   if (crash_done) next_state = (lives == 2'd0) ? OVER : LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            lane_load <= 1'b0;
        end else begin
            cur_state <= next_state;
            lane_load <= (next_state == LOAD);
        end
    end

    // Prescaler restarts on LOAD and on entry to CRASH so the crash lasts a fixed time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc     <= '0;
            crash_cnt <= '0;
        end else begin
            if (cur_state == LOAD || (cur_state == RUN && next_state == CRASH))
                presc <= '0;
            else if (cur_state == RUN || cur_state == CRASH)
                presc <= base_tick ? '0 : presc + 1'b1;

            if (cur_state != CRASH)
                crash_cnt <= '0;
            else if (base_tick)
                crash_cnt <= crash_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 3'd0;
            lives <= 2'(LIVES);
        end else begin
            if (cur_state == OVER && start) begin
                level <= 3'd0;
                lives <= 2'(LIVES);
            end else if (cur_state == RUN) begin
                if (collision) begin
                    if (lives != 2'd0) lives <= lives - 2'd1;
                end else if (level_up && level != 3'd7) begin
                    level <= level + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            move_tick <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                move_tick[i] <= (cur_state == RUN) && base_tick && (lane_cnt[i] == 4'd1);
                if (cur_state == LOAD)
                    lane_cnt[i] <= period[i];
                else if (cur_state == RUN && base_tick)
                    lane_cnt[i] <= (lane_cnt[i] == 4'd1) ? period[i] : lane_cnt[i] - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed self-checking bench for traffic_scheduler with a short prescaler
// so that lane periods, pause phase and crash timing are visible cycle by cycle.
module tb_traffic_scheduler;

    localparam int          NUM_LANES   = 4;
    localparam int          PRESCALE    = 4;
    localparam logic [15:0] LANE_BASE   = 16'h8642;
    localparam int          CRASH_TICKS = 2;
    localparam int          LIVES       = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       collision;
    logic       level_up;
    logic [3:0] move_tick;
    logic       lane_load;
    logic [7:0] lane_dir;
    logic [2:0] level;
    logic [1:0] lives;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    traffic_scheduler #(
        .NUM_LANES  (NUM_LANES),
        .PRESCALE   (PRESCALE),
        .LANE_BASE  (LANE_BASE),
        .CRASH_TICKS(CRASH_TICKS),
        .LIVES      (LIVES)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pause    (pause),
        .collision(collision),
        .level_up (level_up),
        .move_tick(move_tick),
        .lane_load(lane_load),
        .lane_dir (lane_dir),
        .level    (level),
        .lives    (lives),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane i pulses at RUN index r when r is a nonzero multiple of period_i*PRESCALE.
    function automatic logic [3:0] exp_tick(input int r, input int lvl);
        logic [15:0] lb;
        logic [3:0]  res;
        int          base;
        int          p;
        lb  = LANE_BASE;
        res = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            base = int'(lb[4*i +: 4]);
            p    = (base > lvl) ? base - lvl : 1;
            res[i] = (r > 0) && (r % (p * PRESCALE) == 0);
        end
        return res;
    endfunction

    task automatic check_run(input int first, input int last, input int lvl, input string tag);
        for (int r = first; r <= last; r++) begin
            check($sformatf("%s_tick_r%0d", tag, r), move_tick, exp_tick(r, lvl));
            step();
        end
    endtask

    task automatic check_crash(input int pause_at, input string tag);
        for (int k = 0; k < CRASH_TICKS * PRESCALE; k++) begin
            check($sformatf("%s_state_c%0d", tag, k), state, 3'd4);
            check($sformatf("%s_tick_c%0d", tag, k), move_tick, 4'd0);
            if (k == pause_at) pause = 1'b1;
            step();
            pause = 1'b0;
        end
    endtask

    task automatic pulse_collision();
        collision = 1'b1;
        step();
        collision = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        collision = 1'b0;
        level_up  = 1'b0;
        #22;
        check("rst_state", state, 3'd0);
        check("rst_level", level, 3'd0);
        check("rst_lives", lives, 2'd3);
        check("rst_tick", move_tick, 4'd0);
        check("rst_load", lane_load, 1'b0);
        check("lane_dir", lane_dir, 8'h44);
        step();
        reset_n = 1'b1;
        step();
        check("idle_state", state, 3'd0);

        $display("[TB] start and base lane periods");
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_state", state, 3'd1);
        check("load_pulse", lane_load, 1'b1);
        step();
        check("run_state", state, 3'd2);
        check("run_load_low", lane_load, 1'b0);
        check_run(0, 48, 0, "lvl0");

        $display("[TB] level up");
        level_up = 1'b1;
        step();
        level_up = 1'b0;
        check("lvlup_state", state, 3'd1);
        check("lvlup_level", level, 3'd1);
        step();
        check_run(0, 28, 1, "lvl1");

        for (int n = 0; n < 8; n++) begin
            level_up = 1'b1;
            step();
            level_up = 1'b0;
            check($sformatf("sat_level_%0d", n), level, (n + 2 > 7) ? 3'd7 : 3'(n + 2));
            step();
        end
        check("sat_state", state, 3'd2);
        check_run(0, 12, 7, "lvl7");

        $display("[TB] collisions");
        pulse_collision();
        check("col1_lives", lives, 2'd2);
        check("col1_level", level, 3'd7);
        check_crash(-1, "crash1");
        check("col1_reload", state, 3'd1);
        check("col1_level_kept", level, 3'd7);
        step();
        check("col1_run", state, 3'd2);

        pulse_collision();
        check("col2_lives", lives, 2'd1);
        check_crash(2, "crash2");
        check("col2_reload", state, 3'd1);
        step();

        pulse_collision();
        check("col3_lives", lives, 2'd0);
        check_crash(-1, "crash3");
        check("over_state", state, 3'd5);
        pulse_collision();
        check("over_ignore", state, 3'd5);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", state, 3'd1);
        check("restart_level", level, 3'd0);
        check("restart_lives", lives, 2'd3);
        step();

        $display("[TB] pause and resume");
        check_run(0, 4, 0, "prepause");
        pause = 1'b1;
        step();
        pause = 1'b0;
        for (int c = 6; c <= 24; c++) begin
            check($sformatf("paused_state_%0d", c), state, 3'd3);
            check($sformatf("paused_tick_%0d", c), move_tick, 4'd0);
            if (c == 10) collision = 1'b1;
            if (c == 12) level_up = 1'b1;
            step();
            collision = 1'b0;
            level_up  = 1'b0;
        end
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("resume_state", state, 3'd2);
        check("resume_lives", lives, 2'd3);
        check("resume_level", level, 3'd0);
        check_run(6, 24, 0, "resumed");

        $display("[TB] simultaneous pulses");
        collision = 1'b1;
        level_up  = 1'b1;
        pause     = 1'b1;
        step();
        collision = 1'b0;
        level_up  = 1'b0;
        pause     = 1'b0;
        check("combo_state", state, 3'd4);
        check("combo_level", level, 3'd0);
        check("combo_lives", lives, 2'd2);
        check_crash(1, "crash4");
        check("combo_reload", state, 3'd1);
        check("combo_level_kept", level, 3'd0);
        step();

        $display("[TB] asynchronous reset mid-run");
        level_up = 1'b1;
        step();
        level_up = 1'b0;
        step();
        check_run(0, 3, 1, "prereset");
        check("prereset_tick", move_tick, 4'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", state, 3'd0);
        check("arst_tick", move_tick, 4'd0);
        check("arst_load", lane_load, 1'b0);
        check("arst_level", level, 3'd0);
        check("arst_lives", lives, 2'd3);
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_idle", state, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
